mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous memory (MEM_SIZE words of MEM_WIDTH bits) between NUM_CORES requesters. Each requester issues one read or write at a time over a req/ack handshake. It sits in the processor top between the per-core memory ports and the shared memory instance, in the divided core clock domain. Transactions are fully serialized: one memory access in flight at a time.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port synchronous memory
// between NUM_CORES requesters. One access in flight at a time, three cycles
// per transaction (IDLE -> ACCESS -> WAIT -> IDLE).
//
// Ports:
//   clk, reset      clock / synchronous active-low reset
//   req, we         per-requester request and write enable
//   addr, wdata     per-requester address / write data, packed by requester
//   ack             one-hot, one-cycle completion pulse
//   rdata           read data, valid in the ack cycle of a read
//   grant           one-hot owner of the in-flight transaction, 0 when idle
//   mem_en, mem_we  memory strobe / write enable
//   mem_addr        memory address
//   mem_wdata       memory write data
//   mem_rdata       memory read data, valid the cycle after mem_en
module mem_arbiter #(
   parameter int NUM_CORES  = 2,
   parameter int MEM_WIDTH  = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_CORES-1:0]            req,
   input  logic [NUM_CORES-1:0]            we,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_CORES*MEM_WIDTH-1:0]  wdata,
   output logic [NUM_CORES-1:0]            ack,
   output logic [MEM_WIDTH-1:0]            rdata,
   output logic [NUM_CORES-1:0]            grant,
   output logic                            mem_en,
   output logic                            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [MEM_WIDTH-1:0]            mem_wdata,
   input  logic [MEM_WIDTH-1:0]            mem_rdata
);
   localparam int LW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

   state_t                r_state, w_next;
   logic [LW-1:0]         r_last;
   logic [NUM_CORES-1:0]  r_grant, r_ack;
   logic                  r_mem_en, r_mem_we, r_is_wr;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [MEM_WIDTH-1:0]  r_mem_wdata, r_rdata;

   logic [NUM_CORES-1:0]  w_elig, w_onehot;
   logic [LW-1:0]         w_win, w_idx;
   logic                  w_found;

   // A requester still holding req in its ack cycle must not be re-granted.
   assign w_elig = req & ~r_ack;

   // Rotating search starting just past the last winner.
   always_comb begin
      w_found  = 1'b0;
      w_win    = '0;
      w_idx    = '0;
      w_onehot = '0;
      for (int i = 1; i <= NUM_CORES; i++) begin
         w_idx = LW'((int'(r_last) + i) % NUM_CORES);
         if (!w_found && w_elig[w_idx]) begin
            w_found         = 1'b1;
            w_win           = w_idx;
            w_onehot[w_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_found) w_next = S_ACCESS;
         S_ACCESS: w_next = S_WAIT;
         S_WAIT:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last      <= LW'(NUM_CORES - 1);
         r_grant     <= '0;
         r_ack       <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_is_wr     <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant     <= w_onehot;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= we[w_win];
                  r_is_wr     <= we[w_win];
                  r_mem_addr  <= addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                  r_mem_wdata <= wdata[int'(w_win)*MEM_WIDTH +: MEM_WIDTH];
                  r_last      <= w_win;
               end
            end
            S_ACCESS: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
            end
            S_WAIT: begin
               r_ack   <= r_grant;
               r_grant <= '0;
               // mem_we is already low here, so the write flag is kept apart.
               if (!r_is_wr) r_rdata <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   assign ack       = r_ack;
   assign grant     = r_grant;
   assign rdata     = r_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter with four requesters, a behavioural
// synchronous memory, and a transaction-level scheduling model that predicts
// every cycle's ack/grant/mem_en/mem_we/rdata from the arbitration rules.
module tb_mem_arbiter;
   localparam int NC = 4, MW = 32, AW = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [NC-1:0]    req, we, ack, grant;
   logic [NC*AW-1:0] addr;
   logic [NC*MW-1:0] wdata;
   logic [MW-1:0]    rdata, mem_wdata, mem_rdata;
   logic             mem_en, mem_we;
   logic [AW-1:0]    mem_addr;

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_CORES(NC), .MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .grant(grant), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   // Memory the arbiter drives: synchronous read, write on mem_en & mem_we.
   logic [MW-1:0] tb_mem [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr] <= mem_wdata;
         mem_rdata <= tb_mem[mem_addr];
      end
   end

   // Reference model state.
   int            n_chk = 0, n_bad = 0, cyc_n = 0, en_cnt = 0;
   logic [MW-1:0] ref_mem [256];
   int            last_m = NC - 1, free_at = 0;
   bit            t_valid = 0, t_we = 0, rst_prev = 0;
   int            t_start = 0, t_core = 0;
   logic [AW-1:0] t_addr;
   logic [MW-1:0] t_wdata, t_rdata, exp_rdata = '0;
   logic [NC-1:0] exp_ack_now = '0, prev_ack = '0;
   bit            rr_mode = 0, rnd_mode = 0;
   int            ack_q[$], ack_t[$];
   int            ack_cnt[NC];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
      end
   endtask

   task automatic set_req(input int c, input bit w, input logic [AW-1:0] a, input logic [MW-1:0] d);
      we[c] = w;
      addr[c*AW +: AW] = a;
      wdata[c*MW +: MW] = d;
      req[c] = 1'b1;
   endtask

   task automatic new_req(input int c);
      set_req(c, 1'($urandom_range(0, 1)), AW'(8'h10 + $urandom_range(0, 7)), MW'($urandom));
   endtask

   // Arbitration for the current cycle using the inputs as they stand now.
   task automatic decide();
      rst_prev = !reset;
      if (!reset) begin
         t_valid = 0; last_m = NC - 1; free_at = cyc_n + 1; exp_rdata = '0;
         return;
      end
      if (cyc_n != free_at) return;
      for (int k = 1; k <= NC; k++) begin
         int c;
         c = (last_m + k) % NC;
         if (req[c] && !exp_ack_now[c]) begin
            t_valid = 1; t_start = cyc_n; t_core = c; t_we = we[c];
            t_addr = addr[c*AW +: AW]; t_wdata = wdata[c*MW +: MW];
            t_rdata = ref_mem[t_addr];
            if (t_we) ref_mem[t_addr] = t_wdata;
            last_m = c; free_at = cyc_n + 3;
            return;
         end
      end
      free_at = cyc_n + 1;
   endtask

   // Advance one clock, check the new cycle, then let the requesters react.
   task automatic next_cycle();
      logic [NC-1:0] e_ack, e_gnt, oh;
      bit            e_en, e_we;
      int            d;
      @(posedge clk); #1;
      cyc_n++;
      e_ack = '0; e_gnt = '0; e_en = 0; e_we = 0; oh = '0; d = -1;
      if (t_valid) begin
         d = cyc_n - t_start;
         oh[t_core] = 1'b1;
         if (d == 1) begin e_en = 1; e_we = t_we; e_gnt = oh; end
         if (d == 2) e_gnt = oh;
         if (d == 3) begin e_ack = oh; if (!t_we) exp_rdata = t_rdata; end
      end
      chk("ack", 64'(ack), 64'(e_ack));
      chk("grant", 64'(grant), 64'(e_gnt));
      chk("mem_en", 64'(mem_en), 64'(e_en));
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("rdata", 64'(rdata), 64'(exp_rdata));
      if (d == 1) chk("mem_addr", 64'(mem_addr), 64'(t_addr));
      if (d == 1 && t_we) chk("mem_wdata", 64'(mem_wdata), 64'(t_wdata));
      if (rst_prev) begin
         chk("rst_addr", 64'(mem_addr), 64'd0);
         chk("rst_wdata", 64'(mem_wdata), 64'd0);
      end
      exp_ack_now = e_ack;
      if (mem_en) en_cnt++;
      for (int i = 0; i < NC; i++) begin
         if (ack[i]) begin ack_q.push_back(i); ack_t.push_back(cyc_n); ack_cnt[i]++; end
      end
      for (int i = 0; i < NC; i++) begin
         if (prev_ack[i]) begin
            if (rr_mode || (rnd_mode && $urandom_range(0, 1) == 1)) new_req(i);
            else req[i] = 1'b0;
         end else if (rnd_mode && !req[i] && $urandom_range(0, 2) == 0) begin
            new_req(i);
         end
      end
      prev_ack = ack;
   endtask

   task automatic cyc();
      decide();
      next_cycle();
   endtask

   task automatic wait_ack(input int c);
      bit got;
      got = 0;
      for (int k = 0; k < 30 && !got; k++) begin
         cyc();
         if (ack[c]) got = 1;
      end
      if (!got) chk("ack_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int c0, e0;
      for (int i = 0; i < 256; i++) begin
         tb_mem[i] = $urandom; ref_mem[i] = tb_mem[i];
      end
      tb_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
      for (int i = 0; i < NC; i++) ack_cnt[i] = 0;
      reset = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;

      // Reset state
      repeat (3) cyc();
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      reset = 1'b1;
      cyc();

      // Single read of core 0
      set_req(0, 0, 8'h10, '0);
      cyc();
      chk("rd_en", 64'(mem_en), 64'd1);
      chk("rd_addr", 64'(mem_addr), 64'h10);
      cyc(); cyc();
      chk("rd_ack", 64'(ack), 64'b0001);
      chk("rd_data", 64'(rdata), 64'hDEADBEEF);
      cyc();
      chk("rd_gnt_after", 64'(grant), 64'd0);

      // Write then read-back by core 1
      set_req(1, 1, 8'h20, 32'h12345678);
      wait_ack(1);
      chk("wr_rdata_hold", 64'(rdata), 64'hDEADBEEF);
      cyc();
      set_req(1, 0, 8'h20, '0);
      wait_ack(1);
      chk("rb_data", 64'(rdata), 64'h12345678);
      cyc();

      // Ack masking: core 2 still holds req in its ack cycle
      c0 = ack_cnt[2]; e0 = en_cnt;
      set_req(2, 0, 8'h11, '0);
      wait_ack(2);
      repeat (6) cyc();
      chk("mask_acks", 64'(ack_cnt[2] - c0), 64'd1);
      chk("mask_en", 64'(en_cnt - e0), 64'd1);

      // Wrap: last = 3, then cores 0 and 3 together
      set_req(3, 0, 8'h12, '0);
      wait_ack(3);
      cyc();
      ack_q.delete();
      set_req(0, 0, 8'h13, '0);
      set_req(3, 1, 8'h14, 32'hA5A5_0003);
      repeat (12) cyc();
      chk("wrap_n", 64'(ack_q.size()), 64'd2);
      chk("wrap_first", 64'(ack_q.size() > 0 ? ack_q[0] : -1), 64'd0);
      chk("wrap_second", 64'(ack_q.size() > 1 ? ack_q[1] : -1), 64'd3);

      // Round-robin under continuous load
      ack_q.delete(); ack_t.delete();
      rr_mode = 1;
      for (int i = 0; i < NC; i++) new_req(i);
      repeat (36) cyc();
      rr_mode = 0;
      repeat (16) cyc();
      chk("rr_cnt", 64'(ack_q.size() >= 12), 64'd1);
      for (int k = 0; k < ack_q.size(); k++) chk("rr_order", 64'(ack_q[k]), 64'(k % NC));
      for (int k = 1; k < ack_t.size(); k++) chk("rr_gap", 64'(ack_t[k] - ack_t[k-1]), 64'd3);

      // Reset during WAIT of a core 0 read
      set_req(0, 0, 8'h10, '0);
      cyc();
      chk("rm_access", 64'(mem_en), 64'd1);
      cyc();
      reset = 1'b0;
      cyc();
      chk("rm_ack", 64'(ack), 64'd0);
      chk("rm_grant", 64'(grant), 64'd0);
      chk("rm_en", 64'(mem_en), 64'd0);
      chk("rm_rdata", 64'(rdata), 64'd0);
      reset = 1'b1;
      ack_q.delete();
      set_req(3, 0, 8'h15, '0);
      repeat (12) cyc();
      chk("rm_first", 64'(ack_q.size() > 0 ? ack_q[0] : -1), 64'd0);

      // Randomised traffic with occasional resets
      rnd_mode = 1;
      repeat (800) begin
         reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         cyc();
      end
      rnd_mode = 0;
      reset = 1'b1;
      repeat (20) cyc();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
